// File: rtl/wbtimer_pkg.sv
// Shared definitions for the Wishbone timer: register offsets, CTRL/STATUS bit
// positions and a byte-lane merge helper.
package wbtimer_pkg;

  // Register offsets, decoded from wb_adr_i[2:0].
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_RELOAD   = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  // CTRL bit positions.
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_RELOAD = 1;
  localparam int unsigned CTRL_IRQEN  = 2;

  // STATUS bit positions.
  localparam int unsigned STATUS_PEND = 0;

  // Replace the bytes of old_val selected by sel with those of new_val.
  function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wbtimer_prescaler.sv
// Prescaler for the Wishbone timer: counts 0..prescale_i while enabled and
// flags a tick in the cycle the count sits at prescale_i.
module wbtimer_prescaler #(
  parameter int unsigned PW = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          clear_i,
  input  logic [PW-1:0] prescale_i,
  output logic          tick_o
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          at_top;

  assign at_top = (cnt_q == prescale_i);
  assign tick_o = en_i & at_top;

  // Next count: wrap at the top, hold at zero while disabled or cleared.
  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clear_i || !en_i || at_top) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wbtimer.sv
// Wishbone-slave down-counter timer with prescaler, auto-reload and a level
// interrupt. Bus decode and the counter live here; the prescaler is separate.
module wbtimer
  import wbtimer_pkg::*;
#(
  parameter int unsigned AW = 30,
  parameter int unsigned DW = 32,
  parameter int unsigned PW = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_ni,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic [DW-1:0]   wb_dat_o,
  input  logic            wb_we_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_cyc_i,
  input  logic            wb_stb_i,
  output logic            wb_ack_o,
  output logic            irq_o
);

  logic [2:0]    adr;
  logic          req, wr;
  logic          wr_ctrl, wr_prescale, wr_count, wr_reload, wr_status;
  logic          tick, tick_eff, psc_clear;
  logic          en_q, en_d, arl_q, arl_d, irqen_q, irqen_d, pend_q, pend_d;
  logic [PW-1:0] prescale_q, prescale_d, prescale_wval;
  logic [31:0]   count_q, count_d, reload_q, reload_d;
  logic          ack_q;
  logic [DW-1:0] dat_q, dat_d, rdata;
  logic [31-PW:0] unused_prescale_hi;
  logic          unused_adr;

  assign unused_adr = ^wb_adr_i[AW-1:3];
  assign adr        = wb_adr_i[2:0];

  // A request is only taken while ack is low, giving one ack per transfer.
  assign req         = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr          = req & wb_we_i;
  assign wr_ctrl     = wr & (adr == REG_CTRL);
  assign wr_prescale = wr & (adr == REG_PRESCALE);
  assign wr_count    = wr & (adr == REG_COUNT);
  assign wr_reload   = wr & (adr == REG_RELOAD);
  assign wr_status   = wr & (adr == REG_STATUS);

  assign {unused_prescale_hi, prescale_wval} = apply_sel(32'(prescale_q), wb_dat_i, wb_sel_i);

  // Prescaler restarts on COUNT/PRESCALE writes and when EN is switched on.
  assign psc_clear = wr_count | wr_prescale |
                     (wr_ctrl & wb_sel_i[0] & wb_dat_i[CTRL_EN] & ~en_q);

  wbtimer_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk_i      (wb_clk_i),
    .rst_ni     (wb_reset_ni),
    .en_i       (en_q),
    .clear_i    (psc_clear),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  // A bus write to COUNT or CTRL swallows a coincident tick entirely.
  assign tick_eff = tick & ~wr_ctrl & ~wr_count;

  // Read mux: register contents as seen in the request cycle.
  always_comb begin
    rdata = '0;
    case (adr)
      REG_CTRL: begin
        rdata[CTRL_EN]     = en_q;
        rdata[CTRL_RELOAD] = arl_q;
        rdata[CTRL_IRQEN]  = irqen_q;
      end
      REG_PRESCALE: rdata = 32'(prescale_q);
      REG_COUNT:    rdata = count_q;
      REG_RELOAD:   rdata = reload_q;
      REG_STATUS:   rdata[STATUS_PEND] = pend_q;
      default:      rdata = '0;
    endcase
  end

  // Register next-state: W1C first so a same-cycle expiry still sets PEND,
  // then the tick, then bus writes (which only coincide with a dropped tick).
  always_comb begin
    en_d       = en_q;
    arl_d      = arl_q;
    irqen_d    = irqen_q;
    pend_d     = pend_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    reload_d   = reload_q;
    dat_d      = req ? rdata : '0;

    if (wr_status && wb_sel_i[0] && wb_dat_i[STATUS_PEND]) pend_d = 1'b0;

    if (tick_eff) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        pend_d = 1'b1;
        if (arl_q) count_d = reload_q;
        else       en_d    = 1'b0;
      end
    end

    if (wr_ctrl && wb_sel_i[0]) begin
      en_d    = wb_dat_i[CTRL_EN];
      arl_d   = wb_dat_i[CTRL_RELOAD];
      irqen_d = wb_dat_i[CTRL_IRQEN];
    end
    if (wr_prescale) prescale_d = prescale_wval;
    if (wr_count)    count_d    = apply_sel(count_q, wb_dat_i, wb_sel_i);
    if (wr_reload)   reload_d   = apply_sel(reload_q, wb_dat_i, wb_sel_i);
  end

  // State and registered bus outputs.
  always_ff @(posedge wb_clk_i or negedge wb_reset_ni) begin
    if (!wb_reset_ni) begin
      en_q       <= 1'b0;
      arl_q      <= 1'b0;
      irqen_q    <= 1'b0;
      pend_q     <= 1'b0;
      prescale_q <= '0;
      count_q    <= '0;
      reload_q   <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      en_q       <= en_d;
      arl_q      <= arl_d;
      irqen_q    <= irqen_d;
      pend_q     <= pend_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      ack_q      <= req;
      dat_q      <= dat_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = pend_q & irqen_q;

endmodule

// File: tb/tb_wbtimer.sv
// Self-checking bench for wbtimer: directed vector tables, hand-written timing
// sequences, and random bus traffic checked every cycle against a reference model.
module tb_wbtimer;
  import wbtimer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [29:0] adr = '0;
  logic [31:0] dat_w = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_r;
  logic        ack, irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  bit mon_en   = 1'b0;

  wbtimer #(
    .AW (30),
    .DW (32),
    .PW (16)
  ) dut (
    .wb_clk_i    (clk),
    .wb_reset_ni (rst_n),
    .wb_adr_i    (adr),
    .wb_dat_i    (dat_w),
    .wb_dat_o    (dat_r),
    .wb_we_i     (we),
    .wb_sel_i    (sel),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_ack_o    (ack),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return (o & ~m) | (n & m);
  endfunction

  // ---------------- Reference model ----------------
  // The timer is modelled as "cycles left until the next tick" (m_ctt), which is
  // reloaded from PRESCALE whenever the prescaler restarts or the timer is off.
  logic        m_en = 0, m_ar = 0, m_ie = 0, m_pend = 0, m_ack = 0;
  logic [15:0] m_pre = '0;
  logic [31:0] m_count = '0, m_reload = '0, m_dat = '0, m_rd, m_v;
  int          m_ctt = 0;
  logic        m_req, m_wr, m_tick, m_restart;
  logic [2:0]  m_a;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_pend = 0; m_ack = 0;
      m_pre = '0; m_count = '0; m_reload = '0; m_dat = '0; m_ctt = 0;
    end else begin
      m_req     = cyc && stb && !m_ack;
      m_wr      = m_req && we;
      m_a       = adr[2:0];
      m_tick    = m_en && (m_ctt == 0);
      m_restart = 1'b0;
      case (m_a)
        3'd0:    m_rd = {29'd0, m_ie, m_ar, m_en};
        3'd1:    m_rd = {16'd0, m_pre};
        3'd2:    m_rd = m_count;
        3'd3:    m_rd = m_reload;
        3'd4:    m_rd = {31'd0, m_pend};
        default: m_rd = '0;
      endcase
      if (m_en) m_ctt = m_tick ? int'(m_pre) : m_ctt - 1;
      if (m_wr && (m_a == 3'd0 || m_a == 3'd2)) m_tick = 1'b0;
      if (m_wr && m_a == 3'd4 && sel[0] && dat_w[0]) m_pend = 1'b0;
      if (m_tick) begin
        if (m_count != 0) m_count = m_count - 1;
        else begin
          m_pend = 1'b1;
          if (m_ar) m_count = m_reload;
          else      m_en = 1'b0;
        end
      end
      if (m_wr) begin
        case (m_a)
          3'd0: begin
            m_v = merge({29'd0, m_ie, m_ar, m_en}, dat_w, sel);
            if (m_v[0] && !m_en) m_restart = 1'b1;
            m_en = m_v[0]; m_ar = m_v[1]; m_ie = m_v[2];
          end
          3'd1: begin
            m_v = merge({16'd0, m_pre}, dat_w, sel);
            m_pre = m_v[15:0];
            m_restart = 1'b1;
          end
          3'd2: begin
            m_count = merge(m_count, dat_w, sel);
            m_restart = 1'b1;
          end
          3'd3: m_reload = merge(m_reload, dat_w, sel);
          default: ;
        endcase
      end
      if (m_restart || !m_en) m_ctt = int'(m_pre);
      m_dat = m_req ? m_rd : '0;
      m_ack = m_req;
    end
  end

  // Every-cycle comparison of bus outputs and interrupt against the model.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("mon_ack", {31'd0, ack}, {31'd0, m_ack});
      chk("mon_irq", {31'd0, irq}, {31'd0, m_pend & m_ie});
      if (m_ack) chk("mon_rdata", dat_r, m_dat);
    end
  end

  // ---------------- Bus helpers ----------------
  // Called #1 after a clock edge with ack low; returns #1 after ack has dropped.
  task automatic bus(input logic w, input logic [2:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output int edge_no);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, a}; dat_w = d; sel = s;
    @(posedge clk); #1;
    edge_no = cyc_cnt;
    chk("ack_one_cycle", {31'd0, ack}, 32'd1);
    rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr32(input logic [2:0] a, input logic [31:0] d);
    logic [31:0] rd; int e;
    bus(1'b1, a, d, 4'hF, rd, e);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] rd; int e;
    bus(1'b0, a, 32'd0, 4'hF, rd, e);
    chk(name, rd, exp);
  endtask

  task automatic wait_irq(input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      if (irq) begin
        edge_no = cyc_cnt;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        c;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic run_table(input string tag);
    logic [31:0] rd; int e;
    foreach (vt[i]) begin
      bus(vt[i].w, vt[i].a, vt[i].d, vt[i].s, rd, e);
      if (vt[i].c) chk($sformatf("%s_vec%0d", tag, i), rd, vt[i].exp);
    end
    vt.delete();
  endtask

  // ---------------- Test sequence ----------------
  initial begin
    logic [31:0] rd;
    int e0, e1, t1, t2, idle;
    logic [2:0] ra;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);

    // Reset contents: every address reads 0.
    for (int i = 0; i < 8; i++) vt.push_back('{1'b0, 3'(i), 32'd0, 4'hF, 1'b1, 32'd0});
    run_table("reset_read");

    // Auto-reload period.
    wr32(REG_PRESCALE, 32'd3);
    wr32(REG_RELOAD, 32'd4);
    wr32(REG_COUNT, 32'd4);
    bus(1'b1, REG_CTRL, 32'h7, 4'hF, rd, e0);
    wait_irq(40, t1);
    chk("reload_first_irq_delay", 32'(t1 - e0), 32'd20);
    rd_chk("reload_count_reloaded", REG_COUNT, 32'd4);
    rd_chk("reload_pend", REG_STATUS, 32'd1);
    wr32(REG_STATUS, 32'd1);
    chk("reload_irq_cleared", {31'd0, irq}, 32'd0);
    wait_irq(40, t2);
    chk("reload_irq_period", 32'(t2 - t1), 32'd20);
    wr32(REG_CTRL, 32'd0);
    wr32(REG_STATUS, 32'd1);

    // One-shot at PRESCALE=0.
    wr32(REG_PRESCALE, 32'd0);
    wr32(REG_COUNT, 32'd2);
    bus(1'b1, REG_CTRL, 32'h5, 4'hF, rd, e0);
    wait_irq(20, t1);
    chk("oneshot_irq_delay", 32'(t1 - e0), 32'd3);
    rd_chk("oneshot_ctrl", REG_CTRL, 32'h4);
    rd_chk("oneshot_count", REG_COUNT, 32'd0);

    // W1C on the very edge PEND sets: set wins.
    wr32(REG_STATUS, 32'd1);
    chk("collide_pre_irq", {31'd0, irq}, 32'd0);
    wr32(REG_COUNT, 32'd2);
    bus(1'b1, REG_CTRL, 32'h5, 4'hF, rd, e0);
    @(posedge clk); #1;
    bus(1'b1, REG_STATUS, 32'd1, 4'hF, rd, e1);
    rd_chk("collide_pend_kept", REG_STATUS, 32'd1);
    chk("collide_irq_high", {31'd0, irq}, 32'd1);
    wr32(REG_STATUS, 32'd1);
    chk("collide_irq_low", {31'd0, irq}, 32'd0);
    rd_chk("collide_pend_cleared", REG_STATUS, 32'd0);

    // Byte lanes and unmapped addresses.
    vt.push_back('{1'b1, REG_CTRL,     32'h0,        4'hF, 1'b0, 32'h0});
    vt.push_back('{1'b1, REG_COUNT,    32'h11223344, 4'hF, 1'b0, 32'h0});
    vt.push_back('{1'b1, REG_COUNT,    32'hAABBCCDD, 4'h1, 1'b0, 32'h0});
    vt.push_back('{1'b0, REG_COUNT,    32'h0,        4'hF, 1'b1, 32'h112233DD});
    vt.push_back('{1'b1, REG_RELOAD,   32'h0,        4'hF, 1'b0, 32'h0});
    vt.push_back('{1'b1, REG_RELOAD,   32'hAABBCCDD, 4'hA, 1'b0, 32'h0});
    vt.push_back('{1'b0, REG_RELOAD,   32'h0,        4'hF, 1'b1, 32'hAA00CC00});
    vt.push_back('{1'b1, REG_PRESCALE, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0});
    vt.push_back('{1'b0, REG_PRESCALE, 32'h0,        4'hF, 1'b1, 32'h0000FFFF});
    vt.push_back('{1'b1, REG_PRESCALE, 32'h12345678, 4'h2, 1'b0, 32'h0});
    vt.push_back('{1'b0, REG_PRESCALE, 32'h0,        4'hF, 1'b1, 32'h000056FF});
    vt.push_back('{1'b1, REG_CTRL,     32'hFFFFFFF8, 4'hF, 1'b0, 32'h0});
    vt.push_back('{1'b0, REG_CTRL,     32'h0,        4'hF, 1'b1, 32'h0});
    vt.push_back('{1'b1, 3'd6,         32'hFFFFFFFF, 4'hF, 1'b0, 32'h0});
    vt.push_back('{1'b0, 3'd6,         32'h0,        4'hF, 1'b1, 32'h0});
    vt.push_back('{1'b0, REG_STATUS,   32'h0,        4'hF, 1'b1, 32'h0});
    run_table("lanes");

    // Reset in the middle of a pending request.
    wr32(REG_PRESCALE, 32'd2);
    wr32(REG_COUNT, 32'd5);
    wr32(REG_CTRL, 32'h4);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {27'd0, REG_COUNT};
    #3 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midreset_no_ack", {31'd0, ack}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 8; i++) vt.push_back('{1'b0, 3'(i), 32'd0, 4'hF, 1'b1, 32'd0});
    run_table("midreset_read");

    // Random traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 300; n++) begin
      idle = $urandom_range(0, 3);
      repeat (idle) begin
        @(posedge clk); #1;
      end
      ra = 3'($urandom_range(0, 7));
      case (ra)
        REG_CTRL:     dat_w = 32'($urandom_range(0, 7));
        REG_PRESCALE: dat_w = 32'($urandom_range(0, 3));
        REG_COUNT:    dat_w = 32'($urandom_range(0, 6));
        REG_RELOAD:   dat_w = 32'($urandom_range(0, 6));
        REG_STATUS:   dat_w = 32'($urandom_range(0, 1));
        default:      dat_w = $urandom;
      endcase
      bus(($urandom_range(0, 2) != 0), ra, dat_w,
          ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, rd, e1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
